// File: rtl/source.sv
// Moore history-tree FSM: tracks the last three serial bits of x and classifies them into y.
// Define SOURCE_YREG_EN to drive y from a flip-flop preloaded with the decode of ns.
module source (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic [1:0] y,
    output logic [3:0] cs,
    output logic [3:0] ns
);

    // Code = 2^len - 1 + val, most recent bit in the LSB of val.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_0    = 4'd1,
        S_1    = 4'd2,
        S_00   = 4'd3,
        S_01   = 4'd4,
        S_10   = 4'd5,
        S_11   = 4'd6,
        S_000  = 4'd7,
        S_001  = 4'd8,
        S_010  = 4'd9,
        S_011  = 4'd10,
        S_100  = 4'd11,
        S_101  = 4'd12,
        S_110  = 4'd13,
        S_111  = 4'd14,
        S_BAD  = 4'd15
    } state_t;

    logic [3:0] cs_reg;
    logic [3:0] ns_next;

    function automatic logic [1:0] y_decode(input logic [3:0] s);
        logic [1:0] r;
        r = 2'b00;
        case (s)
            S_101:   r = 2'b01;
            S_000:   r = 2'b10;
            S_111:   r = 2'b11;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_reg <= S_IDLE;
        end else begin
            cs_reg <= ns_next;
        end
    end

    // Full-window states shift the oldest bit out; shorter histories grow by one level.
    always_comb begin
        ns_next = S_IDLE;
        case (cs_reg)
            S_IDLE:        ns_next = x ? S_1   : S_0;
            S_0:           ns_next = x ? S_01  : S_00;
            S_1:           ns_next = x ? S_11  : S_10;
            S_00:          ns_next = x ? S_001 : S_000;
            S_01:          ns_next = x ? S_011 : S_010;
            S_10:          ns_next = x ? S_101 : S_100;
            S_11:          ns_next = x ? S_111 : S_110;
            S_000, S_100:  ns_next = x ? S_001 : S_000;
            S_001, S_101:  ns_next = x ? S_011 : S_010;
            S_010, S_110:  ns_next = x ? S_101 : S_100;
            S_011, S_111:  ns_next = x ? S_111 : S_110;
            default:       ns_next = S_IDLE;
        endcase
    end

    assign cs = cs_reg;
    assign ns = ns_next;

`ifdef SOURCE_YREG_EN
    logic [1:0] y_reg;

    // Loading the decode of the next state keeps y aligned with cs, one flop deep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_reg <= 2'b00;
        end else begin
            y_reg <= y_decode(ns_next);
        end
    end

    assign y = y_reg;
`else
    assign y = y_decode(cs_reg);
`endif

endmodule

// File: tb/tb_source.sv
// Randomised and directed bench for source against a len/val history model.
module tb_source;

    logic       clk;
    logic       rst;
    logic       x;
    logic [1:0] y;
    logic [3:0] cs;
    logic [3:0] ns;

    int tests_run;
    int tests_failed;

    // Reference model: how many bits seen (saturating at 3) and their value.
    int m_len;
    int m_val;

    source dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .cs  (cs),
        .ns  (ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int code_of(input int len, input int val);
        return (1 << len) - 1 + val;
    endfunction

    function automatic int y_of(input int len, input int val);
        if (len != 3) return 0;
        if (val == 5) return 1;
        if (val == 0) return 2;
        if (val == 7) return 3;
        return 0;
    endfunction

    function automatic int next_code(input int len, input int val, input int b);
        if (len < 3) return code_of(len + 1, val * 2 + b);
        return code_of(3, (val * 2 + b) % 8);
    endfunction

    task automatic do_bit(input logic b, input string tag);
        x = b;
        #1;
        check({tag, " ns"}, int'(ns), next_code(m_len, m_val, int'(b)));
        @(posedge clk);
        #1;
        if (m_len < 3) m_len++;
        m_val = (m_val * 2 + int'(b)) % (1 << m_len);
        check({tag, " cs"}, int'(cs), code_of(m_len, m_val));
        check({tag, " y"}, int'(y), y_of(m_len, m_val));
    endtask

    task automatic do_reset(input logic b, input string tag);
        rst = 1'b0;
        x = b;
        @(posedge clk);
        #1;
        m_len = 0;
        m_val = 0;
        check({tag, " cs"}, int'(cs), 0);
        check({tag, " y"}, int'(y), 0);
        check({tag, " ns"}, int'(ns), b ? 2 : 1);
        rst = 1'b1;
    endtask

    initial begin
        int alt_cs [6] = '{2, 5, 12, 9, 12, 9};
        int alt_y  [6] = '{0, 0, 1, 0, 1, 0};
        tests_run = 0;
        tests_failed = 0;
        m_len = 0;
        m_val = 0;
        rst = 1'b0;
        x = 1'b1;
        #2;

        // Reset with x=1, then a single 1
        do_reset(1'b1, "rst_x1");
        do_bit(1'b1, "after_rst_1");
        check("after_rst cs=2", int'(cs), 2);

        // Alternating from IDLE, with explicit expected codes as well as the model
        do_reset(1'b0, "alt_rst");
        for (int i = 0; i < 6; i++) begin
            do_bit(((i % 2) == 0) ? 1'b1 : 1'b0, $sformatf("alt%0d", i));
            check($sformatf("alt%0d cs_tab", i), int'(cs), alt_cs[i]);
            check($sformatf("alt%0d y_tab", i), int'(y), alt_y[i]);
        end

        // All zeros
        do_reset(1'b0, "zero_rst");
        for (int i = 0; i < 5; i++) do_bit(1'b0, $sformatf("zero%0d", i));
        check("zero cs=7", int'(cs), 7);
        check("zero y=10", int'(y), 2);
        check("zero ns=7", int'(ns), 7);

        // All ones then a zero
        do_reset(1'b0, "one_rst");
        for (int i = 0; i < 4; i++) do_bit(1'b1, $sformatf("one%0d", i));
        check("one y=11", int'(y), 3);
        do_bit(1'b0, "one_then0");
        check("one_then0 cs=13", int'(cs), 13);

        // Mid-stream reset discards history
        do_reset(1'b0, "mid_rst0");
        for (int i = 0; i < 3; i++) do_bit(1'b1, $sformatf("mid%0d", i));
        check("mid cs=14", int'(cs), 14);
        do_reset(1'b1, "mid_rst1");
        do_bit(1'b1, "mid_a");
        do_bit(1'b1, "mid_b");
        check("mid_b cs=6", int'(cs), 6);
        check("mid_b y=00", int'(y), 0);

        // Illegal code 15 recovers to IDLE
        do_reset(1'b0, "ill_rst");
        force dut.cs_reg = 4'd15;
        x = 1'b0;
        #1;
        check("ill cs", int'(cs), 15);
        check("ill y x0", int'(y), 0);
        check("ill ns x0", int'(ns), 0);
        x = 1'b1;
        #1;
        check("ill ns x1", int'(ns), 0);
        check("ill y x1", int'(y), 0);
        release dut.cs_reg;
        @(posedge clk);
        #1;
        check("ill recover cs", int'(cs), 0);
        check("ill recover y", int'(y), 0);
        m_len = 0;
        m_val = 0;

        // Random bits with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                do_reset(1'($urandom_range(0, 1)), $sformatf("rnd_rst%0d", i));
            else
                do_bit(1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/source.md
Name: source

Overview:
- Moore finite-state machine that tracks the most recent three serial input bits and classifies them into a 2-bit pattern code y.
- Exposes its current state (cs) and combinational next state (ns) for waveform-level debug and verification.
- Sits at the head of the serial-stimulus path; x is sampled once per clock on the rising edge.

Parameters:
- None. State width is fixed at 4 bits and output width at 2 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising clk edge
- x    input  1  serial data bit, sampled on the rising clk edge
- y    output 2  Moore pattern code; decoded from cs only
- cs   output 4  current state register
- ns   output 4  combinational next state computed from cs and x

Behaviour:
- State encoding is a history tree, code = 2^len - 1 + val:
  - len = number of bits received since reset, saturating at 3.
  - val = those bits, with the most recent bit as LSB.
  - len 0 -> code 0 (IDLE).
  - len 1 -> codes 1..2.
  - len 2 -> codes 3..6.
  - len 3 -> codes 7..14.
  - Code 15 is illegal.
- Next state (ns, purely combinational, changes within the same cycle as x or cs):
  - If len < 3: len' = len+1, val' = {val, x}.
  - If len = 3: len' = 3, val' = {val[1:0], x}.
  - If cs = 15: ns = 0 for any x.
- Register update on the rising clk edge:
  - If rst = 0: cs <= 0.
  - Otherwise: cs <= ns.
  - Reset has priority over x. Reset asserted mid-stream discards all history; the next three bits must be received again before y can be nonzero.
- Output y, a function of cs only (Moore):
  - 00 for all len < 3 states and for code 15.
  - For len = 3, val 101 (code 12) -> 01.
  - For len = 3, val 000 (code 7) -> 10.
  - For len = 3, val 111 (code 14) -> 11.
  - Every other len = 3 value -> 00.
- Latency:
  - A bit sampled at edge k is reflected in cs and y immediately after edge k.
  - The first nonzero y can appear no earlier than after the 3rd sampled bit following reset release.
- Overlap: detection is sliding-window and fully overlapping. For example, 10101 yields y = 01 after bits 3 and 5.
- Reset values: cs = 0, y = 00. ns = 1 if x = 0, ns = 2 if x = 1 (combinational, also during reset).
- Power-up: cs is undefined until the first clock edge with rst = 0.

Optional Feature:
- Macro: SOURCE_YREG_EN.
- Defined:
  - y is driven directly by a flip-flop loaded with the y-decode of ns on every rising edge.
  - The flop is loaded with 00 when rst = 0.
  - Cycle timing of y is identical to the undefined case, but y is glitch-free and has no combinational path from cs.
- Undefined: y is a combinational decode of cs.
- Both builds must be cycle-equivalent on y for every legal stimulus.

Test Plan:
- Reset: hold rst=0 for 1 edge with x=1 -> cs=0, y=00, ns=2; release rst, apply x=1 -> cs=2, y=00.
- Alternating 1,0,1,0,1,0 from IDLE:
  - cs after each edge = 2, 5, 12, 9, 12, 9.
  - y = 00, 00, 01, 00, 01, 00.
- All zeros from IDLE:
  - cs = 1, 3, 7, 7, 7.
  - y = 00, 00, 10, 10, 10.
  - ns stays 7 once cs = 7 and x = 0.
- All ones from IDLE:
  - cs = 2, 6, 14, 14.
  - y = 00, 00, 11, 11.
  - One following 0 -> cs = 13, y = 00.
- Mid-stream reset: drive 1,1,1 (cs=14, y=11), assert rst=0 for one edge -> cs=0, y=00; then 1,1 -> cs = 2, 6, with y = 00 throughout.
- Illegal state: force cs=15 -> y=00 and ns=0 for x=0 and x=1; after the next edge cs=0. Repeat all scenarios with SOURCE_YREG_EN defined and confirm identical y.
